gpio_irq_banked: RTL and testbench



---
 rtl/gpio_irq_banked.sv | 122 ++++++++++++
 tb/tb_gpio_irq_banked.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq_banked.sv
// Banked GPIO edge-detect interrupt front-end with an Avalon-MM slave.
// Ports: clk, rst_n, gpio_i, avs_* bus, irq_o (one level irq per bank).
module gpio_irq_banked #(
  parameter  int NUM_GPIO    = 72,
  parameter  int SYNC_STAGES = 2,
  localparam int NUM_BANKS   = (NUM_GPIO + 31) / 32,
  localparam int ADDR_W      = $clog2(NUM_BANKS) + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_GPIO-1:0]  gpio_i,
  input  logic [ADDR_W-1:0]    avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 avs_readdatavalid,
  output logic [NUM_BANKS-1:0] irq_o
);

  localparam int PW = NUM_BANKS * 32;

  logic [NUM_GPIO-1:0] sync_q [SYNC_STAGES];
  logic [NUM_GPIO-1:0] prev_q;
  logic [NUM_GPIO-1:0] s;
  logic [PW-1:0]       rise_pad;
  logic [PW-1:0]       fall_pad;
  logic [PW-1:0]       impl_pad;

  logic [31:0] pend_q [NUM_BANKS];
  logic [31:0] ien_q  [NUM_BANKS];
  logic [31:0] rise_q [NUM_BANKS];
  logic [31:0] fall_q [NUM_BANKS];

  logic [7:0]  bank_idx;
  logic [1:0]  reg_idx;
  logic [31:0] rd_mux;

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise_pad = PW'(s & ~prev_q);
  assign fall_pad = PW'(~s & prev_q);
  assign impl_pad = PW'({NUM_GPIO{1'b1}});
  assign reg_idx  = avs_address[1:0];

  if (ADDR_W > 2) begin : g_bank
    assign bank_idx = 8'(avs_address[ADDR_W-1:2]);
  end else begin : g_nobank
    assign bank_idx = 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      prev_q <= s;
    end
  end

  // Set is OR'ed in after the W1C mask so a coincident edge survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        pend_q[b] <= '0;
        ien_q[b]  <= '0;
        rise_q[b] <= '0;
        fall_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        logic        sel;
        logic [31:0] msk;
        logic [31:0] set;
        logic [31:0] clr;
        sel = avs_write && (bank_idx == 8'(b));
        msk = impl_pad[b*32 +: 32];
        set = (rise_pad[b*32 +: 32] & rise_q[b])
            | (fall_pad[b*32 +: 32] & fall_q[b]);
        clr = (sel && reg_idx == 2'd0) ? avs_writedata : 32'd0;
        pend_q[b] <= ((pend_q[b] & ~clr) | set) & msk;
        if (sel && reg_idx == 2'd1) ien_q[b]  <= avs_writedata & msk;
        if (sel && reg_idx == 2'd2) rise_q[b] <= avs_writedata & msk;
        if (sel && reg_idx == 2'd3) fall_q[b] <= avs_writedata & msk;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_idx == 8'(b)) begin
        unique case (reg_idx)
          2'd0: rd_mux = pend_q[b];
          2'd1: rd_mux = ien_q[b];
          2'd2: rd_mux = rise_q[b];
          2'd3: rd_mux = fall_q[b];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

  always_comb begin
    irq_o = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      irq_o[b] = |(pend_q[b] & ien_q[b]);
  end

endmodule

// File: tb/tb_gpio_irq_banked.sv
// Directed testbench for gpio_irq_banked (NUM_GPIO=72, SYNC_STAGES=2).
// Table of bus vectors plus hand sequences for edge/irq corner cases.
module tb_gpio_irq_banked;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [71:0] gpio_i = '0;
  logic [3:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [2:0]  irq_o;

  int checks = 0;
  int failures = 0;

  gpio_irq_banked #(.NUM_GPIO(72), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .gpio_i(gpio_i),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic bus_write(logic [3:0] a, logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    @(posedge clk);
    #1 avs_write = 1'b0;
  endtask

  task automatic bus_read(logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_read = 1'b1;
    @(posedge clk);
    #1 avs_read = 1'b0;
    check("rdvalid", 32'(avs_readdatavalid), 32'd1);
    d = avs_readdata;
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;

    // reset state
    #12;
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_rdata", avs_readdata, 32'd0);
    check("rst_rvalid", 32'(avs_readdatavalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      vecs.push_back('{1'b0, 4'(i), 32'd0, 32'd0});
    vecs.push_back('{1'b1, 4'd1,  32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{1'b0, 4'd1,  32'd0, 32'hFFFF_FFFF});
    vecs.push_back('{1'b1, 4'd2,  32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{1'b0, 4'd2,  32'd0, 32'hFFFF_FFFF});
    vecs.push_back('{1'b1, 4'd10, 32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{1'b0, 4'd10, 32'd0, 32'h0000_00FF});
    vecs.push_back('{1'b1, 4'd11, 32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{1'b0, 4'd11, 32'd0, 32'h0000_00FF});
    vecs.push_back('{1'b1, 4'd14, 32'h1234_5678, 32'd0});
    vecs.push_back('{1'b0, 4'd14, 32'd0, 32'd0});
    vecs.push_back('{1'b1, 4'd7,  32'h0000_0100, 32'd0});
    vecs.push_back('{1'b0, 4'd7,  32'd0, 32'h0000_0100});
    vecs.push_back('{1'b1, 4'd5,  32'd0, 32'd0});
    vecs.push_back('{1'b0, 4'd5,  32'd0, 32'd0});

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, d);
        check($sformatf("vec%0d_a%0d", i, vecs[i].addr), d, vecs[i].exp);
      end
    end
    check("irq_idle", 32'(irq_o), 32'd0);
    cycles(1);
    check("rvalid_idle", 32'(avs_readdatavalid), 32'd0);

    // rising edge on pin 5: pending at edge k+3
    @(posedge clk);
    #1 gpio_i[5] = 1'b1;
    cycles(2);
    check("p5_early_irq", 32'(irq_o), 32'd0);
    gpio_i[5] = 1'b0;
    cycles(1);
    check("p5_irq", 32'(irq_o), 32'd1);
    bus_read(4'd0, d);
    check("p5_pend", d, 32'h20);
    bus_write(4'd0, 32'h20);
    check("p5_irq_clr", 32'(irq_o), 32'd0);
    bus_read(4'd0, d);
    check("p5_pend_clr", d, 32'd0);

    // falling edge on pin 40, IEN1 off
    gpio_i[40] = 1'b1;
    cycles(4);
    bus_read(4'd4, d);
    check("p40_no_rise", d, 32'd0);
    gpio_i[40] = 1'b0;
    cycles(4);
    bus_read(4'd4, d);
    check("p40_fall", d, 32'h100);
    check("p40_irq_off", 32'(irq_o), 32'd0);
    bus_write(4'd5, 32'h100);
    check("p40_irq_on", 32'(irq_o), 32'b010);
    bus_write(4'd4, 32'h100);
    check("p40_irq_clr", 32'(irq_o), 32'd0);

    // both edges on pin 71, unimplemented bits stay 0
    gpio_i[71] = 1'b1;
    cycles(4);
    bus_read(4'd8, d);
    check("p71_rise", d, 32'h80);
    bus_write(4'd8, 32'hFFFF_FFFF);
    bus_read(4'd8, d);
    check("p71_clr", d, 32'd0);
    gpio_i[71] = 1'b0;
    cycles(4);
    bus_read(4'd8, d);
    check("p71_fall", d, 32'h80);
    check("p71_irq_off", 32'(irq_o), 32'd0);
    bus_write(4'd8, 32'hFFFF_FFFF);
    bus_read(4'd8, d);
    check("p71_clr2", d, 32'd0);

    // set wins over coincident W1C on pin 3
    @(posedge clk);
    #1 gpio_i[3] = 1'b1;
    cycles(2);
    bus_write(4'd0, 32'h8);
    check("p3_irq", 32'(irq_o), 32'd1);
    bus_read(4'd0, d);
    check("p3_set_wins", d, 32'h8);
    bus_write(4'd0, 32'h1);
    bus_read(4'd0, d);
    check("p3_w0_keep", d, 32'h8);
    bus_write(4'd0, 32'h8);
    bus_read(4'd0, d);
    check("p3_w1c", d, 32'd0);

    // read+write same register returns the old value
    @(negedge clk);
    avs_address = 4'd5;
    avs_writedata = 32'hA5;
    avs_read = 1'b1;
    avs_write = 1'b1;
    @(posedge clk);
    #1 avs_read = 1'b0;
    avs_write = 1'b0;
    check("rw_old", avs_readdata, 32'h100);
    cycles(1);
    check("rdata_hold", avs_readdata, 32'h100);
    bus_read(4'd5, d);
    check("rw_new", d, 32'hA5);

    // async reset while bank 0 irq is active
    @(posedge clk);
    #1 gpio_i[0] = 1'b1;
    cycles(4);
    check("p0_irq", 32'(irq_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_irq", 32'(irq_o), 32'd0);
    check("async_rvalid", 32'(avs_readdatavalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(4);
    for (int a = 0; a < 12; a++) begin
      bus_read(4'(a), d);
      check($sformatf("post_rst_a%0d", a), d, 32'd0);
    end
    check("post_rst_irq", 32'(irq_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
